// File: rtl/cpu_clk_ctrl.sv
// Run-control front end for the pipelined CPU: synchronizes switches, debounces the step
// button and issues a single-cycle pipeline clock-enable in SLOW, STEP or FAST mode.
module cpu_clk_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned SLOW_PERIOD     = 33554432,
    parameter int unsigned SW_W            = 16
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic [SW_W-1:0] sw_i,
    input  logic            btn_step_i,
    input  logic            halt_i,
    output logic [SW_W-1:0] sw_sync_o,
    output logic            cpu_en_o,
    output logic [1:0]      mode_o,
    output logic [31:0]     cycle_cnt_o,
    output logic            btn_db_o
);

    localparam int unsigned DIV_W = (SLOW_PERIOD > 2) ? $clog2(SLOW_PERIOD) : 1;
    localparam int unsigned DEB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SLOW_PERIOD - 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        MODE_SLOW = 2'b00,
        MODE_STEP = 2'b01,
        MODE_FAST = 2'b10
    } mode_t;

    typedef enum logic [1:0] {
        ST_ARM   = 2'b00,
        ST_PULSE = 2'b01,
        ST_HOLD  = 2'b10
    } step_t;

    logic [SW_W-1:0]  sw_meta_reg;
    logic [SW_W-1:0]  sw_sync_reg;
    logic             btn_meta_reg;
    logic             btn_sync_reg;

    mode_t            mode_reg;
    mode_t            mode_next;
    logic             mode_chg;

    logic [DEB_W-1:0] deb_cnt_reg;
    logic [DEB_W-1:0] deb_cnt_next;
    logic             btn_db_reg;
    logic             btn_db_next;

    step_t            step_reg;
    step_t            step_next;
    logic             step_pulse;

    logic [DIV_W-1:0] div_reg;
    logic [DIV_W-1:0] div_next;

    logic             cpu_en_reg;
    logic             cpu_en_next;
    logic [31:0]      cycle_cnt_reg;
    logic [31:0]      cycle_cnt_next;

    // Two-flop synchronizers for the asynchronous board inputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sw_meta_reg  <= '0;
            sw_sync_reg  <= '0;
            btn_meta_reg <= 1'b0;
            btn_sync_reg <= 1'b0;
        end else begin
            sw_meta_reg  <= sw_i;
            sw_sync_reg  <= sw_meta_reg;
            btn_meta_reg <= btn_step_i;
            btn_sync_reg <= btn_meta_reg;
        end
    end

    always_comb begin
        mode_next = MODE_SLOW;
        if (sw_sync_reg[14]) begin
            mode_next = MODE_FAST;
        end else if (sw_sync_reg[13]) begin
            mode_next = MODE_STEP;
        end
    end

    // A pending mode switch blocks every enable source of the outgoing mode.
    assign mode_chg = (mode_next != mode_reg);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mode_reg <= MODE_SLOW;
        end else begin
            mode_reg <= mode_next;
        end
    end

    always_comb begin
        btn_db_next  = btn_db_reg;
        deb_cnt_next = '0;
        if (btn_sync_reg != btn_db_reg) begin
            if (deb_cnt_reg == DEB_LAST) begin
                btn_db_next = ~btn_db_reg;
            end else begin
                deb_cnt_next = deb_cnt_reg + DEB_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            deb_cnt_reg <= '0;
            btn_db_reg  <= 1'b0;
        end else begin
            deb_cnt_reg <= deb_cnt_next;
            btn_db_reg  <= btn_db_next;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            step_reg <= ST_ARM;
        end else begin
            step_reg <= step_next;
        end
    end

    // Outside a stable STEP mode the FSM parks so that a press already held never pulses.
    always_comb begin
        step_next  = step_reg;
        step_pulse = 1'b0;
        if (mode_reg != MODE_STEP || mode_chg) begin
            step_next = btn_db_reg ? ST_HOLD : ST_ARM;
        end else begin
            case (step_reg)
                ST_ARM: begin
                    if (btn_db_reg) begin
                        step_next = ST_PULSE;
                    end
                end
                ST_PULSE: begin
                    step_pulse = 1'b1;
                    step_next  = ST_HOLD;
                end
                ST_HOLD: begin
                    if (!btn_db_reg) begin
                        step_next = ST_ARM;
                    end
                end
                default: begin
                    step_next = ST_ARM;
                end
            endcase
        end
    end

    // The divider keeps running under halt so the slow cadence is not disturbed.
    always_comb begin
        div_next = '0;
        if (!mode_chg && mode_reg == MODE_SLOW && div_reg != DIV_LAST) begin
            div_next = div_reg + DIV_W'(1);
        end
    end

    always_comb begin
        cpu_en_next = 1'b0;
        if (!mode_chg) begin
            case (mode_reg)
                MODE_FAST: cpu_en_next = ~halt_i;
                MODE_SLOW: cpu_en_next = ~halt_i && (div_reg == DIV_LAST);
                MODE_STEP: cpu_en_next = step_pulse;
                default:   cpu_en_next = 1'b0;
            endcase
        end
    end

    assign cycle_cnt_next = cycle_cnt_reg + {31'd0, cpu_en_reg};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            div_reg       <= '0;
            cpu_en_reg    <= 1'b0;
            cycle_cnt_reg <= '0;
        end else begin
            div_reg       <= div_next;
            cpu_en_reg    <= cpu_en_next;
            cycle_cnt_reg <= cycle_cnt_next;
        end
    end

    assign sw_sync_o   = sw_sync_reg;
    assign cpu_en_o    = cpu_en_reg;
    assign mode_o      = mode_reg;
    assign cycle_cnt_o = cycle_cnt_reg;
    assign btn_db_o    = btn_db_reg;

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Bench for cpu_clk_ctrl: directed vector table, hand sequences for corner cases and a
// randomized run, all checked cycle by cycle against a rule-level reference model.
module tb_cpu_clk_ctrl;

    localparam int DEB    = 4;
    localparam int SLOW_P = 5;
    localparam int NV     = 23;

    logic        clk;
    logic        rstn;
    logic [15:0] sw_i;
    logic        btn_step_i;
    logic        halt_i;
    logic [15:0] sw_sync_o;
    logic        cpu_en_o;
    logic [1:0]  mode_o;
    logic [31:0] cycle_cnt_o;
    logic        btn_db_o;

    cpu_clk_ctrl #(
        .DEBOUNCE_CYCLES(DEB),
        .SLOW_PERIOD    (SLOW_P),
        .SW_W           (16)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .sw_i       (sw_i),
        .btn_step_i (btn_step_i),
        .halt_i     (halt_i),
        .sw_sync_o  (sw_sync_o),
        .cpu_en_o   (cpu_en_o),
        .mode_o     (mode_o),
        .cycle_cnt_o(cycle_cnt_o),
        .btn_db_o   (btn_db_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] sw;
        logic        btn;
        logic        halt;
        int          cycles;
        int          exp_pulses;   // -1: pulse count depends on phase, model check only
    } vec_t;

    vec_t tbl [0:NV-1];

    int checks = 0;
    int errors = 0;

    // Reference model state: what the board should look like after each clock edge.
    logic [15:0] m_sw_meta, m_sw_sync;
    logic        m_btn_meta, m_btn_sync;
    logic [1:0]  m_mode;
    int          m_phase;
    logic        m_en;
    logic [31:0] m_cnt;
    logic        m_db;
    int          m_run;
    bit          m_armed;
    bit          m_pending;

    function automatic logic [1:0] mode_of(input logic [15:0] s);
        if (s[14]) return 2'b10;
        if (s[13]) return 2'b01;
        return 2'b00;
    endfunction

    task automatic model_reset();
        m_sw_meta  = '0;
        m_sw_sync  = '0;
        m_btn_meta = 1'b0;
        m_btn_sync = 1'b0;
        m_mode     = 2'b00;
        m_phase    = 0;
        m_en       = 1'b0;
        m_cnt      = '0;
        m_db       = 1'b0;
        m_run      = 0;
        m_armed    = 1'b1;
        m_pending  = 1'b0;
    endtask

    task automatic model_edge(input logic [15:0] sw, input logic btn, input logic halt);
        logic [1:0] new_mode;
        bit         switching;
        logic       new_en;
        new_mode  = mode_of(m_sw_sync);
        switching = (new_mode != m_mode);
        new_en    = 1'b0;
        if (!switching) begin
            if (m_mode == 2'b10)      new_en = !halt;
            else if (m_mode == 2'b00) new_en = !halt && (m_phase == SLOW_P - 1);
            else                      new_en = m_pending;
        end
        m_cnt = m_cnt + (m_en ? 32'd1 : 32'd0);
        // one pulse per press that begins (debounced) while STEP is already selected
        if (switching || m_mode != 2'b01) begin
            m_armed   = !m_db;
            m_pending = 1'b0;
        end else if (m_pending) begin
            m_pending = 1'b0;
        end else if (m_armed && m_db) begin
            m_pending = 1'b1;
            m_armed   = 1'b0;
        end else if (!m_armed && !m_db) begin
            m_armed = 1'b1;
        end
        m_phase = (switching || m_mode != 2'b00) ? 0 : (m_phase + 1) % SLOW_P;
        if (m_btn_sync != m_db) begin
            m_run = m_run + 1;
            if (m_run == DEB) begin
                m_db  = !m_db;
                m_run = 0;
            end
        end else begin
            m_run = 0;
        end
        m_en       = new_en;
        m_mode     = new_mode;
        m_sw_sync  = m_sw_meta;
        m_sw_meta  = sw;
        m_btn_sync = m_btn_meta;
        m_btn_meta = btn;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_outputs(input string tag);
        chk({tag, "_en"},   {31'd0, cpu_en_o}, {31'd0, m_en});
        chk({tag, "_mode"}, {30'd0, mode_o},   {30'd0, m_mode});
        chk({tag, "_cnt"},  cycle_cnt_o,       m_cnt);
        chk({tag, "_db"},   {31'd0, btn_db_o}, {31'd0, m_db});
        chk({tag, "_sw"},   {16'd0, sw_sync_o}, {16'd0, m_sw_sync});
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_en"},   {31'd0, cpu_en_o}, 32'd0);
        chk({tag, "_mode"}, {30'd0, mode_o},   32'd0);
        chk({tag, "_cnt"},  cycle_cnt_o,       32'd0);
        chk({tag, "_db"},   {31'd0, btn_db_o}, 32'd0);
        chk({tag, "_sw"},   {16'd0, sw_sync_o}, 32'd0);
    endtask

    // Called at a falling edge: drive, clock once, then compare at the next falling edge.
    task automatic step_cycle(input logic [15:0] sw, input logic btn, input logic halt);
        sw_i       = sw;
        btn_step_i = btn;
        halt_i     = halt;
        @(posedge clk);
        model_edge(sw, btn, halt);
        @(negedge clk);
        chk_outputs("cyc");
    endtask

    task automatic run_vec(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            int pulses;
            pulses = 0;
            for (int k = 0; k < tbl[i].cycles; k++) begin
                step_cycle(tbl[i].sw, tbl[i].btn, tbl[i].halt);
                if (cpu_en_o) pulses++;
            end
            if (tbl[i].exp_pulses >= 0)
                chk($sformatf("vec%0d_pulses", i), pulses, tbl[i].exp_pulses);
            $display("vec %0d: sw=%h btn=%0b halt=%0b cycles=%0d pulses=%0d cnt=%0d",
                     i, tbl[i].sw, tbl[i].btn, tbl[i].halt, tbl[i].cycles, pulses, cycle_cnt_o);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got time limit, expected simulation end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int       n;
        int       pulses;
        logic [31:0] c0;
        logic     rbtn;

        // SLOW free run
        tbl[0]  = '{16'h0000, 1'b0, 1'b0, 30, 6};
        // STEP: two presses of different length, then a short glitch
        tbl[1]  = '{16'h2000, 1'b0, 1'b0, 6, 0};
        tbl[2]  = '{16'h2000, 1'b0, 1'b0, 10, 0};
        tbl[3]  = '{16'h2000, 1'b1, 1'b0, 6, 0};
        tbl[4]  = '{16'h2000, 1'b0, 1'b0, 10, 1};
        tbl[5]  = '{16'h2000, 1'b1, 1'b0, 3, 0};
        tbl[6]  = '{16'h2000, 1'b0, 1'b0, 8, 0};
        // FAST with a halt window
        tbl[7]  = '{16'h4000, 1'b0, 1'b0, 13, 10};
        tbl[8]  = '{16'h4000, 1'b0, 1'b1, 10, 0};
        tbl[9]  = '{16'h4000, 1'b0, 1'b0, 10, 10};
        // press held across SLOW -> STEP, then a halted step
        tbl[10] = '{16'h0000, 1'b0, 1'b0, 10, -1};
        tbl[11] = '{16'h0000, 1'b1, 1'b0, 10, -1};
        tbl[12] = '{16'h2000, 1'b1, 1'b0, 3, -1};
        tbl[13] = '{16'h2000, 1'b1, 1'b0, 10, 0};
        tbl[14] = '{16'h2000, 1'b0, 1'b0, 10, 0};
        tbl[15] = '{16'h2000, 1'b1, 1'b1, 12, 1};
        tbl[16] = '{16'h2000, 1'b0, 1'b1, 10, 0};
        // counter wrap around a single FAST pulse
        tbl[17] = '{16'h4000, 1'b0, 1'b1, 6, 0};
        tbl[18] = '{16'h4000, 1'b0, 1'b0, 1, 1};
        tbl[19] = '{16'h4000, 1'b0, 1'b1, 3, 0};
        // mid-SLOW run before an asynchronous reset
        tbl[20] = '{16'h1234, 1'b0, 1'b0, 8, -1};
        tbl[21] = '{16'h0000, 1'b0, 1'b0, 1, -1};
        tbl[22] = '{16'h0000, 1'b0, 1'b0, 1, -1};

        rstn       = 1'b0;
        sw_i       = 16'hFFFF;
        btn_step_i = 1'b1;
        halt_i     = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        sw_i       = 16'h0000;
        btn_step_i = 1'b0;
        @(negedge clk);
        rstn = 1'b1;

        run_vec(0, 1);

        // debounced level must follow a raw press after 2 sync + DEB stable cycles
        c0 = cycle_cnt_o;
        n  = 0;
        pulses = 0;
        while (!btn_db_o && n < 20) begin
            step_cycle(16'h2000, 1'b1, 1'b0);
            if (cpu_en_o) pulses++;
            n++;
        end
        chk("db_rise_latency", n, 6);
        for (int k = n; k < 20; k++) begin
            step_cycle(16'h2000, 1'b1, 1'b0);
            if (cpu_en_o) pulses++;
        end
        chk("long_press_pulses", pulses, 1);
        $display("seq long_press: db_latency=%0d pulses=%0d", n, pulses);
        run_vec(2, 4);
        chk("step_cnt_delta", cycle_cnt_o - c0, 32'd2);

        run_vec(5, 17);

        force dut.cycle_cnt_reg = 32'hFFFF_FFFF;
        m_cnt = 32'hFFFF_FFFF;
        step_cycle(16'h4000, 1'b0, 1'b1);
        release dut.cycle_cnt_reg;
        step_cycle(16'h4000, 1'b0, 1'b1);
        chk("cnt_preload", cycle_cnt_o, 32'hFFFF_FFFF);
        run_vec(18, 19);
        chk("cnt_wrap", cycle_cnt_o, 32'h0000_0000);
        $display("seq wrap: cnt=%h", cycle_cnt_o);

        run_vec(20, 20);
        #2;
        rstn = 1'b0;
        #1;
        chk_all_zero("async_rst");
        @(posedge clk);
        @(negedge clk);
        chk_all_zero("rst_held");
        sw_i = 16'h0000;
        rstn = 1'b1;
        model_reset();
        n = 0;
        do begin
            step_cycle(16'h0000, 1'b0, 1'b0);
            n++;
        end while (!cpu_en_o && n < 20);
        chk("slow_restart_cycles", n, SLOW_P);
        $display("seq async_reset: first pulse after %0d cycles", n);
        run_vec(21, 22);

        rbtn = 1'b0;
        for (int b = 0; b < 20; b++) begin
            logic [15:0] s;
            int          len;
            int          p;
            s = 16'($urandom) & 16'h9FFF;
            case ($urandom_range(0, 3))
                1: s[13] = 1'b1;
                2: s[14] = 1'b1;
                3: s[14:13] = 2'b11;
                default: ;
            endcase
            len = $urandom_range(6, 24);
            p = 0;
            for (int k = 0; k < len; k++) begin
                if ($urandom_range(0, 5) == 0) rbtn = ~rbtn;
                step_cycle(s, rbtn, ($urandom_range(0, 4) == 0));
                if (cpu_en_o) p++;
            end
            $display("rand %0d: sw=%h cycles=%0d pulses=%0d cnt=%0d", b, s, len, p, cycle_cnt_o);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_clk_ctrl.md
Name: cpu_clk_ctrl

Overview:
- Front-end run-control block placed between board I/O and the pipelined CPU core.
- Synchronizes the raw slide switches and debounces the step push-button.
- Produces a single-cycle clock-enable pulse, cpu_en_o, that gates every pipeline register and the PC. This replaces direct clock muxing of the board clock and a divider bit.
- Supports three modes (fast run, slow run, single-step) and a halt request from the core. Counts issued CPU cycles for the display path.

Parameters:
- DEBOUNCE_CYCLES, 1000000: consecutive stable clk cycles the synchronized button needs before its debounced value changes.
- SLOW_PERIOD, 33554432: clk cycles between enable pulses in SLOW mode; must be ≥ 2.
- SW_W, 16: switch bus width.

Ports:
- clk  input  1  board clock.
- rstn  input  1  asynchronous active-low reset.
- sw_i  input  SW_W  raw slide switches.
- btn_step_i  input  1  raw step push-button, active-high.
- halt_i  input  1  halt request from the core (e.g. ebreak retired), level.
- sw_sync_o  output  SW_W  2-flop-synchronized switches.
- cpu_en_o  output  1  registered pipeline clock-enable pulse.
- mode_o  output  2  current mode: 00 SLOW, 01 STEP, 10 FAST.
- cycle_cnt_o  output  32  number of cpu_en_o pulses issued since reset.
- btn_db_o  output  1  debounced button level.

Behaviour:
- Reset state: all flops clear asynchronously on rstn low.
  - sw_sync_o = 0, cpu_en_o = 0, mode_o = 00, cycle_cnt_o = 0, btn_db_o = 0.
  - Step FSM in ARM; divider counter = 0; debounce counter = 0.
- Synchronizer: sw_i and btn_step_i each pass through 2 flops. sw_sync_o lags sw_i by 2 cycles. Switches are not debounced.
- Mode register, updated every cycle from sw_sync_o:
  - sw_sync_o[14] = 1 → FAST.
  - else sw_sync_o[13] = 1 → STEP.
  - else SLOW.
  - mode_o therefore lags sw_i by 3 cycles.
- Debounce:
  - Counter clears whenever the synchronized button equals btn_db_o; otherwise it increments.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, btn_db_o toggles and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES never changes btn_db_o.
- Step FSM (active only in STEP mode):
  - ARM: on btn_db_o = 1 → PULSE.
  - PULSE: drives cpu_en_o = 1 for exactly one cycle → HOLD.
  - HOLD: waits for btn_db_o = 0 → ARM.
  - Result: one button press gives exactly one enable pulse, regardless of press duration.
  - In any other mode, or on a mode change, the FSM is forced to HOLD if btn_db_o = 1, else to ARM. A press held across a mode switch into STEP issues no pulse.
- FAST: cpu_en_o = 1 on every cycle in which the registered mode is FAST and halt_i = 0, with 1 cycle of registration latency.
- SLOW:
  - Divider counts 0..SLOW_PERIOD-1 and wraps.
  - cpu_en_o = 1 for one cycle on the cycle after the counter equals SLOW_PERIOD-1, if halt_i = 0.
  - The divider clears to 0 on every mode transition and holds at 0 outside SLOW.
- Halt:
  - halt_i = 1 suppresses enables in FAST and SLOW; the SLOW divider keeps counting.
  - In STEP mode halt_i is ignored, so a halted core can still be stepped for debug.
  - Deasserting halt_i resumes enables at the next eligible cycle; no pulses are queued.
- cycle_cnt_o increments by 1 in the cycle after each cpu_en_o pulse and wraps from 0xFFFFFFFF to 0.
- Simultaneous events: a mode change and an enable condition in the same cycle are resolved using the new mode; no pulse is issued from the old mode.
- Reset mid-operation: an in-flight PULSE is dropped and the counters clear immediately.

Test Plan:
Bench parameters: DEBOUNCE_CYCLES = 4, SLOW_PERIOD = 5.
1. Reset, sw_i = 0, halt_i = 0, run 30 cycles → mode_o = 00; cpu_en_o pulses once every 5 cycles, single-cycle width; cycle_cnt_o = 5 or 6 depending on phase, always matching the pulse count.
2. sw_i[13] = 1, then press btn_step_i for 20 cycles, release, press again for 6 cycles → exactly 2 cpu_en_o pulses, each 1 cycle wide; cycle_cnt_o increases by 2; btn_db_o rises 6 cycles after each raw press (2 sync + 4 debounce).
3. STEP mode, button glitch 3 cycles high → btn_db_o stays 0, no cpu_en_o pulse.
4. sw_i[14] = 1, halt_i = 0 for 10 cycles, then halt_i = 1 for 10 cycles, then halt_i = 0 → 10 consecutive pulses, none while halted, resume 1 cycle after halt_i drops; cycle_cnt_o = total high cycles.
5. Hold the button in SLOW mode, switch to STEP while still held → no pulse until release and re-press; STEP with halt_i = 1 → press still yields 1 pulse.
6. Preload cycle_cnt_o to 0xFFFFFFFF via forced state, one FAST pulse → 0x00000000; assert rstn low mid-SLOW count → all outputs 0 asynchronously, divider restarts at 0.
